// File: rtl/irrigation_scheduler.sv
// Round-robin outlet-valve scheduler for up to eight irrigation zones.
// One zone watered at a time; min/max grant length, tank holds and a closed-valve gap between grants.
module irrigation_scheduler #(
  parameter int ZONES      = 4,
  parameter int MIN_CYCLES = 100,
  parameter int MAX_CYCLES = 1000,
  parameter int GAP_CYCLES = 10,
  parameter int TW         = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ZONES-1:0]           zoneReq,
  input  logic                       tankOk,
  input  logic                       alarm,
  output logic [ZONES-1:0]           grant,
  output logic                       outletValve,
  output logic [$clog2(ZONES)-1:0]   zoneIdx,
  output logic                       busy,
  output logic                       holding,
  output logic [ZONES-1:0]           overrun
);

  localparam int IW = $clog2(ZONES);
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, WATER, HOLD, GAP} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    ptr, ptr_nx, sel, idx_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic [GW-1:0]    gapcnt, gapcnt_nx;
  logic [ZONES-1:0] grant_nx, ovr_nx, rot;
  logic             valve_nx, found;
  logic [IW:0]      selw;

  // First requesting zone at or after ptr, wrapping modulo ZONES.
  always_comb begin
    rot   = ZONES'({zoneReq, zoneReq} >> ptr);
    found = 1'b0;
    selw  = '0;
    for (int i = 0; i < ZONES; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        selw  = {1'b0, ptr} + (IW+1)'(i);
      end
    end
    if (selw >= (IW+1)'(ZONES)) selw = selw - (IW+1)'(ZONES);
    sel = selw[IW-1:0];
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    timer_nx  = timer;
    gapcnt_nx = gapcnt;
    idx_nx    = zoneIdx;
    grant_nx  = grant;
    valve_nx  = outletValve;
    ovr_nx    = overrun;
    case (state)
      IDLE: begin
        if (tankOk && !alarm && (|zoneReq)) begin
          state_nx = WATER;
          idx_nx   = sel;
          grant_nx = ZONES'(1) << sel;
          valve_nx = 1'b1;
          timer_nx = '0;
        end
      end
      WATER: begin
        if (timer == TW'(MAX_CYCLES - 1) ||
            (timer >= TW'(MIN_CYCLES - 1) && !zoneReq[zoneIdx])) begin
          state_nx         = GAP;
          grant_nx         = '0;
          valve_nx         = 1'b0;
          gapcnt_nx        = '0;
          ptr_nx           = (zoneIdx == IW'(ZONES - 1)) ? '0 : zoneIdx + IW'(1);
          ovr_nx[zoneIdx]  = (timer == TW'(MAX_CYCLES - 1));
        end else if (alarm || !tankOk) begin
          state_nx = HOLD;
          valve_nx = 1'b0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      HOLD: begin
        // Resuming counts the interrupted WATER cycle as done.
        if (tankOk && !alarm) begin
          state_nx = WATER;
          valve_nx = 1'b1;
          timer_nx = timer + TW'(1);
        end
      end
      GAP: begin
        if (gapcnt == GW'(GAP_CYCLES - 1)) state_nx = IDLE;
        else gapcnt_nx = gapcnt + GW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      timer       <= '0;
      gapcnt      <= '0;
      zoneIdx     <= '0;
      grant       <= '0;
      outletValve <= 1'b0;
      busy        <= 1'b0;
      holding     <= 1'b0;
      overrun     <= '0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      timer       <= timer_nx;
      gapcnt      <= gapcnt_nx;
      zoneIdx     <= idx_nx;
      grant       <= grant_nx;
      outletValve <= valve_nx;
      busy        <= (state_nx != IDLE);
      holding     <= (state_nx == HOLD);
      overrun     <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: behavioural zone-service model checked every cycle,
// plus per-grant logs (zone, open-valve cycles, hold cycles, gap) pinned to literals.
module tb_irrigation_scheduler;

  localparam int ZONES = 4;
  localparam int MINC  = 4;
  localparam int MAXC  = 8;
  localparam int GAPC  = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       zoneReq;
  logic             tankOk, alarm;
  logic [3:0]       grant, overrun;
  logic             outletValve, busy, holding;
  logic [1:0]       zoneIdx;

  irrigation_scheduler #(
    .ZONES(ZONES), .MIN_CYCLES(MINC), .MAX_CYCLES(MAXC), .GAP_CYCLES(GAPC), .TW(16)
  ) dut (
    .clock(clock), .reset(reset), .zoneReq(zoneReq), .tankOk(tankOk), .alarm(alarm),
    .grant(grant), .outletValve(outletValve), .zoneIdx(zoneIdx), .busy(busy),
    .holding(holding), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: which zone is being served, whether it is paused, how many
  // open-valve cycles it has had, and how many gap cycles remain.
  bit         m_active, m_paused;
  int         m_zone, m_ptr, m_wcount, m_gap;
  logic [3:0] m_ovr;

  initial begin
    m_active = 0; m_paused = 0; m_zone = 0; m_ptr = 0; m_wcount = 0; m_gap = 0; m_ovr = '0;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_active = 0; m_paused = 0; m_zone = 0; m_ptr = 0; m_wcount = 0; m_gap = 0; m_ovr = '0;
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (m_active && m_paused) begin
        if (tankOk && !alarm) m_paused = 0;
      end else if (m_active) begin
        m_wcount++;
        if (m_wcount == MAXC || (m_wcount >= MINC && !zoneReq[m_zone])) begin
          m_ovr[m_zone] = (m_wcount == MAXC);
          m_active = 0;
          m_gap    = GAPC;
          m_ptr    = (m_zone + 1) % ZONES;
        end else if (!tankOk || alarm) begin
          m_paused = 1;
        end
      end else if (tankOk && !alarm && zoneReq != 0) begin
        for (int i = ZONES - 1; i >= 0; i--)
          if (zoneReq[(m_ptr + i) % ZONES]) m_zone = (m_ptr + i) % ZONES;
        m_active = 1;
        m_wcount = 0;
      end
    end
  end

  // Per-grant log.
  int lz[16], lw[16], lh[16], lg[16];
  int ln = 0, gapc = 0;
  logic [3:0] pg = '0;

  always @(negedge clock) begin
    if (chk_on) begin
      chk("grant",       grant,       m_active ? (1 << m_zone) : 0);
      chk("outletValve", outletValve, (m_active && !m_paused) ? 1 : 0);
      chk("zoneIdx",     zoneIdx,     m_zone);
      chk("busy",        busy,        (m_active || m_gap > 0) ? 1 : 0);
      chk("holding",     holding,     m_paused ? 1 : 0);
      chk("overrun",     overrun,     m_ovr);
    end
    if (grant != 0 && pg == 0) begin
      if (ln < 16) begin
        lz[ln] = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) lz[ln] = i;
        lw[ln] = 0; lh[ln] = 0; lg[ln] = gapc;
      end
      ln++;
    end
    if (grant != 0 && ln >= 1 && ln <= 16) begin
      if (outletValve) lw[ln-1]++;
      if (holding) lh[ln-1]++;
    end
    if (grant == 0) gapc++; else gapc = 0;
    pg = grant;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; zoneReq = '0; tankOk = 1'b1; alarm = 1'b0;
    step(1);
    chk_on = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);

    // Round-robin with requests 1011 held: zones 0,1,3,0, each overruns.
    ln = 0;
    zoneReq = 4'b1011;
    step(42);
    zoneReq = 4'b0000;
    step(4);
    chk("rr_count", ln, 4);
    chk("rr_z0", lz[0], 0);
    chk("rr_z1", lz[1], 1);
    chk("rr_z2", lz[2], 3);
    chk("rr_z3", lz[3], 0);
    for (int i = 0; i < 4; i++) chk("rr_water", lw[i], 8);
    for (int i = 1; i < 4; i++) chk("rr_gap", lg[i], 3);
    chk("rr_overrun", overrun, 4'b1011);

    // Alarm at k=7: overrun wins over hold.
    ln = 0;
    zoneReq = 4'b0100;
    step(8);
    alarm = 1'b1;
    step(1);
    chk("sim_holding", holding, 0);
    chk("sim_valve", outletValve, 0);
    chk("sim_ovr2", overrun[2], 1);
    alarm = 1'b0; zoneReq = 4'b0000;
    step(4);
    chk("sim_zone", lz[0], 2);
    chk("sim_water", lw[0], 8);

    // Zone 0 served again, request drops at k=5: overrun[0] cleared.
    ln = 0;
    zoneReq = 4'b0001;
    step(6);
    zoneReq = 4'b0000;
    step(4);
    chk("clr_zone", lz[0], 0);
    chk("clr_water", lw[0], 6);
    chk("clr_overrun", overrun, 4'b1110);

    // One-cycle pulse on zone 1: exactly MIN cycles.
    ln = 0;
    zoneReq = 4'b0010;
    step(1);
    zoneReq = 4'b0000;
    step(7);
    chk("min_zone", lz[0], 1);
    chk("min_water", lw[0], 4);
    chk("min_overrun", overrun, 4'b1100);

    // tankOk low for 5 cycles from k=2 on zone 0.
    ln = 0;
    zoneReq = 4'b0001;
    step(3);
    tankOk = 1'b0;
    step(3);
    chk("hold_grant", grant, 4'b0001);
    chk("hold_flag", holding, 1);
    chk("hold_valve", outletValve, 0);
    step(2);
    tankOk = 1'b1;
    step(6);
    zoneReq = 4'b0000;
    step(4);
    chk("hold_zone", lz[0], 0);
    chk("hold_water", lw[0], 8);
    chk("hold_cycles", lh[0], 5);
    chk("hold_overrun", overrun, 4'b1101);

    // Reset mid-WATER on zone 2, then next grant goes to zone 0.
    zoneReq = 4'b0100;
    step(3);
    chk("rst_pre_grant", grant, 4'b0100);
    reset = 1'b1;
    step(1);
    chk("rst_grant", grant, 0);
    chk("rst_valve", outletValve, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zoneIdx", zoneIdx, 0);
    reset = 1'b0;
    zoneReq = 4'b0101;
    step(1);
    chk("rst_next_grant", grant, 4'b0001);
    zoneReq = 4'b0000;
    step(8);
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
